ed25519_io_frame: RTL and testbench

//   Stream framing stage between the 64-bit ed25519 I/O ports and the point-multiplication core.
//   - Input side: deserialises one 12-word frame (scalar k, point x, point y) into 256-bit operands.
//   - Start: launches the core with a one-cycle start pulse.
//   - Output side: captures the core result (Qx, Qy) and serialises it as 8 words on the output handshake.

---
 rtl/ed25519_pkg.sv | 20 ++
 rtl/ed25519_word_shift.sv | 28 ++
 rtl/ed25519_io_frame.sv | 133 +++++++++++++
 tb/tb_ed25519_io_frame.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ed25519_pkg.sv
// Shared constants and types for the ed25519 stream framing stage.
// Operands arrive and leave as 64-bit words, most significant word first.
package ed25519_pkg;

    localparam int unsigned DATA_W    = 64;
    localparam int unsigned PATN_W    = 256;
    localparam int unsigned IO_CYCLE  = PATN_W / DATA_W;
    localparam int unsigned IN_WORDS  = 3 * IO_CYCLE;
    localparam int unsigned OUT_WORDS = 2 * IO_CYCLE;
    localparam int unsigned CNT_W     = 4;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        SEND = 2'd2
    } io_state_t;

    typedef logic [PATN_W-1:0] fe_t;

endpackage

// File: rtl/ed25519_word_shift.sv
// Word-granular register with a parallel load and a left shift that inserts one word at the LSB end.
// Parallel load takes priority over shifting.
module ed25519_word_shift #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned WORDS  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic [DATA_W*WORDS-1:0]  load_data,
    input  logic                     shift,
    input  logic [DATA_W-1:0]        shift_in,
    output logic [DATA_W*WORDS-1:0]  q
);

    localparam int unsigned REG_W = DATA_W * WORDS;

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_data;
        end else if (shift) begin
            q <= {q[REG_W-DATA_W-1:0], shift_in};
        end
    end

endmodule

// File: rtl/ed25519_io_frame.sv
// Frames a 12-word input stream into k/x/y operands for the point-multiplication core,
// then streams the 8-word result (Qx then Qy, MSW first) back out.
module ed25519_io_frame
    import ed25519_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [DATA_W-1:0] o_out_data,
    output logic              o_core_start,
    output logic [PATN_W-1:0] o_scalar,
    output logic [PATN_W-1:0] o_px,
    output logic [PATN_W-1:0] o_py,
    input  logic              i_core_done,
    input  logic [PATN_W-1:0] i_qx,
    input  logic [PATN_W-1:0] i_qy
);

    io_state_t               state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    start_q, start_d;
    logic                    valid_q, valid_d;
    logic                    in_shift, out_load, out_shift;
    logic                    in_acc, out_acc;
    logic [3*PATN_W-1:0]     in_q;
    logic [2*PATN_W-1:0]     out_q;

    // Ready depends only on registered state and reset, never on i_in_valid.
    assign o_in_ready = (state_q == LOAD) && !i_rst;
    assign in_acc     = i_in_valid && o_in_ready;
    assign out_acc    = valid_q && i_out_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            start_q <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start_q <= start_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        start_d   = 1'b0;
        valid_d   = valid_q;
        in_shift  = 1'b0;
        out_load  = 1'b0;
        out_shift = 1'b0;
        case (state_q)
            LOAD: begin
                if (in_acc) begin
                    in_shift = 1'b1;
                    if (cnt_q == CNT_W'(IN_WORDS - 1)) begin
                        cnt_d   = '0;
                        state_d = CALC;
                        start_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            CALC: begin
                if (i_core_done) begin
                    out_load = 1'b1;
                    valid_d  = 1'b1;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (out_acc) begin
                    out_shift = 1'b1;
                    if (cnt_q == CNT_W'(OUT_WORDS - 1)) begin
                        cnt_d   = '0;
                        valid_d = 1'b0;
                        state_d = LOAD;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = LOAD;
                cnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    ed25519_word_shift #(
        .DATA_W (DATA_W),
        .WORDS  (IN_WORDS)
    ) u_in_shift (
        .clk       (i_clk),
        .rst       (i_rst),
        .load      (1'b0),
        .load_data ('0),
        .shift     (in_shift),
        .shift_in  (i_in_data),
        .q         (in_q)
    );

    ed25519_word_shift #(
        .DATA_W (DATA_W),
        .WORDS  (OUT_WORDS)
    ) u_out_shift (
        .clk       (i_clk),
        .rst       (i_rst),
        .load      (out_load),
        .load_data ({i_qx, i_qy}),
        .shift     (out_shift),
        .shift_in  ('0),
        .q         (out_q)
    );

    // First accepted word ends up in the top slot, so k occupies the upper third.
    assign o_scalar     = in_q[3*PATN_W-1 -: PATN_W];
    assign o_px         = in_q[2*PATN_W-1 -: PATN_W];
    assign o_py         = in_q[PATN_W-1:0];
    assign o_out_data   = out_q[2*PATN_W-1 -: DATA_W];
    assign o_out_valid  = valid_q;
    assign o_core_start = start_q;

endmodule

// File: tb/tb_ed25519_io_frame.sv
// Directed/randomised bench for ed25519_io_frame: drives frames, models the core,
// and compares operands and output words against values computed from the frame contents.
module tb_ed25519_io_frame;
    import ed25519_pkg::*;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic              i_in_valid;
    logic              o_in_ready;
    logic [DATA_W-1:0] i_in_data;
    logic              o_out_valid;
    logic              i_out_ready;
    logic [DATA_W-1:0] o_out_data;
    logic              o_core_start;
    logic [PATN_W-1:0] o_scalar, o_px, o_py;
    logic              i_core_done;
    logic [PATN_W-1:0] i_qx, i_qy;

    int checks    = 0;
    int failures  = 0;
    int start_cnt = 0;

    ed25519_io_frame dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_in_valid   (i_in_valid),
        .o_in_ready   (o_in_ready),
        .i_in_data    (i_in_data),
        .o_out_valid  (o_out_valid),
        .i_out_ready  (i_out_ready),
        .o_out_data   (o_out_data),
        .o_core_start (o_core_start),
        .o_scalar     (o_scalar),
        .o_px         (o_px),
        .o_py         (o_py),
        .i_core_done  (i_core_done),
        .i_qx         (i_qx),
        .i_qy         (i_qy)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) if (o_core_start) start_cnt <= start_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [PATN_W-1:0] obs, input logic [PATN_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic fe_t rand_fe();
        fe_t v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Offers words 0..n-1 of the frame {k,x,y}, MSW first; returns at the negedge before the accepting edge.
    task automatic send_words(input fe_t k, input fe_t x, input fe_t y, input int n, input bit rnd);
        fe_t ops [3];
        ops = '{k, x, y};
        for (int i = 0; i < n; i++) begin
            bit done = 1'b0;
            int tries = 0;
            while (!done && tries < 200) begin
                @(negedge i_clk);
                i_in_data  = ops[i/4][PATN_W-1-DATA_W*(i%4) -: DATA_W];
                i_in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                done = i_in_valid && o_in_ready;
                tries++;
            end
            chk("in_accept", {255'd0, done}, 256'd1);
        end
    endtask

    task automatic send_frame(input fe_t k, input fe_t x, input fe_t y, input bit rnd, input bit junk);
        int s0;
        s0 = start_cnt;
        send_words(k, x, y, IN_WORDS, rnd);
        @(negedge i_clk);
        i_in_valid = junk;
        i_in_data  = $urandom;
        chk("start_pulse", {255'd0, o_core_start}, 256'd1);
        chk("scalar", o_scalar, k);
        chk("px", o_px, x);
        chk("py", o_py, y);
        chk("ready_calc", {255'd0, o_in_ready}, 256'd0);
        @(negedge i_clk);
        chk("start_single", {255'd0, o_core_start}, 256'd0);
        chk("start_count", PATN_W'(start_cnt), PATN_W'(s0 + 1));
    endtask

    task automatic run_core(input fe_t qx, input fe_t qy, input int delay, input bit junk);
        repeat (delay) begin
            @(negedge i_clk);
            i_in_valid = junk;
            i_in_data  = $urandom;
            chk("ready_wait", {255'd0, o_in_ready}, 256'd0);
            chk("valid_wait", {255'd0, o_out_valid}, 256'd0);
        end
        @(negedge i_clk);
        i_core_done = 1'b1;
        i_qx = qx;
        i_qy = qy;
        @(negedge i_clk);
        i_core_done = 1'b0;
        i_qx = rand_fe();
        i_qy = rand_fe();
        chk("out_valid_latency", {255'd0, o_out_valid}, 256'd1);
    endtask

    // Called at the negedge where the first output word is already valid.
    task automatic recv(input fe_t qx, input fe_t qy, input bit rnd, input bit junk);
        logic [DATA_W-1:0] exp;
        for (int w = 0; w < OUT_WORDS; w++) begin
            bit done = 1'b0;
            int tries = 0;
            exp = (w < IO_CYCLE) ? qx[PATN_W-1-DATA_W*w -: DATA_W]
                                 : qy[PATN_W-1-DATA_W*(w-IO_CYCLE) -: DATA_W];
            while (!done && tries < 200) begin
                i_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                i_in_valid  = junk;
                chk("ready_send", {255'd0, o_in_ready}, 256'd0);
                if (!rnd) chk("out_consecutive", {255'd0, o_out_valid}, 256'd1);
                if (o_out_valid) chk($sformatf("out_word%0d", w), PATN_W'(o_out_data), PATN_W'(exp));
                done = o_out_valid && i_out_ready;
                tries++;
                @(negedge i_clk);
            end
            chk("out_accept", {255'd0, done}, 256'd1);
        end
        i_out_ready = 1'b0;
        i_in_valid  = 1'b0;
        chk("valid_drop", {255'd0, o_out_valid}, 256'd0);
        chk("ready_back", {255'd0, o_in_ready}, 256'd1);
    endtask

    initial begin
        fe_t k, x, y, qx, qy;
        int s0;
        i_rst = 1'b1; i_in_valid = 1'b0; i_in_data = '0; i_out_ready = 1'b0;
        i_core_done = 1'b0; i_qx = '0; i_qy = '0;

        // Reset state
        repeat (2) @(negedge i_clk);
        chk("ready_in_reset", {255'd0, o_in_ready}, 256'd0);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("rst_ready", {255'd0, o_in_ready}, 256'd1);
        chk("rst_valid", {255'd0, o_out_valid}, 256'd0);
        chk("rst_data", PATN_W'(o_out_data), 256'd0);
        chk("rst_start", {255'd0, o_core_start}, 256'd0);
        chk("rst_scalar", o_scalar, 256'd0);
        chk("rst_px", o_px, 256'd0);

        // Fixed frame, always-ready output
        k = {32{8'h01}}; x = {32{8'h02}}; y = {32{8'h03}};
        qx = {32{8'hAA}}; qy = {32{8'h55}};
        send_frame(k, x, y, 1'b0, 1'b0);
        run_core(qx, qy, 20, 1'b0);
        recv(qx, qy, 1'b0, 1'b0);

        // Same frame with random handshakes
        send_frame(k, x, y, 1'b1, 1'b0);
        run_core(qx, qy, 20, 1'b0);
        recv(qx, qy, 1'b1, 1'b0);

        // Reset after 7 words, then a fresh frame
        s0 = start_cnt;
        send_words(rand_fe(), rand_fe(), rand_fe(), 7, 1'b1);
        @(negedge i_clk);
        i_in_valid = 1'b0;
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("ready_mid_reset", {255'd0, o_in_ready}, 256'd0);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("partial_discard", o_scalar, 256'd0);
        chk("partial_no_start", PATN_W'(start_cnt), PATN_W'(s0));
        k = rand_fe(); x = rand_fe(); y = rand_fe(); qx = rand_fe(); qy = rand_fe();
        send_frame(k, x, y, 1'b1, 1'b0);
        run_core(qx, qy, 5, 1'b0);
        recv(qx, qy, 1'b1, 1'b0);

        // Spurious done in LOAD, junk input valid during CALC/SEND
        @(negedge i_clk);
        i_core_done = 1'b1;
        @(negedge i_clk);
        i_core_done = 1'b0;
        chk("spurious_valid", {255'd0, o_out_valid}, 256'd0);
        chk("spurious_ready", {255'd0, o_in_ready}, 256'd1);
        k = rand_fe(); x = rand_fe(); y = rand_fe(); qx = rand_fe(); qy = rand_fe();
        send_frame(k, x, y, 1'b0, 1'b1);
        run_core(qx, qy, 8, 1'b1);
        recv(qx, qy, 1'b1, 1'b1);

        // Two random frames back to back
        for (int f = 0; f < 2; f++) begin
            k = rand_fe(); x = rand_fe(); y = rand_fe(); qx = rand_fe(); qy = rand_fe();
            send_frame(k, x, y, 1'b1, 1'b0);
            run_core(qx, qy, $urandom_range(1, 20), 1'b0);
            recv(qx, qy, 1'b1, 1'b0);
        end

        // Reset while a result is waiting to be sent
        k = rand_fe(); x = rand_fe(); y = rand_fe(); qx = rand_fe(); qy = rand_fe();
        send_frame(k, x, y, 1'b0, 1'b0);
        run_core(qx, qy, 3, 1'b0);
        i_out_ready = 1'b0;
        @(negedge i_clk);
        chk("send_held", PATN_W'(o_out_data), PATN_W'(qx[PATN_W-1 -: DATA_W]));
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        chk("send_reset_valid", {255'd0, o_out_valid}, 256'd0);
        chk("send_reset_data", PATN_W'(o_out_data), 256'd0);
        @(negedge i_clk);
        chk("send_reset_ready", {255'd0, o_in_ready}, 256'd1);
        chk("send_reset_start", {255'd0, o_core_start}, 256'd0);

        // Frame after that reset still frames correctly
        k = rand_fe(); x = rand_fe(); y = rand_fe(); qx = rand_fe(); qy = rand_fe();
        send_frame(k, x, y, 1'b1, 1'b0);
        run_core(qx, qy, 4, 1'b0);
        recv(qx, qy, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
